// File: rtl/sc_bi_scaled_decoder.sv
`default_nettype none
// ============================================================================
// Module  : sc_bi_scaled_decoder
// Brief   : Counts ones of a bipolar stochastic stream over a 2^WIN_LOG2
//           window and rescales the result back to the full MAC sum.
// Revision: 1.0 - initial release
// ============================================================================
module sc_bi_scaled_decoder #(
    parameter int WIN_LOG2   = 8,
    parameter int SCALE_LOG2 = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           iBit,
    input  logic                           iEn,
    input  logic                           iAck,
    output logic                           oBusy,
    output logic                           oValid,
    output logic [WIN_LOG2:0]              oOnes,
    output logic [WIN_LOG2+SCALE_LOG2+1:0] oSum
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_COUNT = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    localparam logic [WIN_LOG2:0] c_WIN_LEN  = (WIN_LOG2+1)'(1 << WIN_LOG2);
    localparam logic [WIN_LOG2:0] c_WIN_LAST = c_WIN_LEN - 1'b1;

    logic [1:0]                           r_state;
    logic [WIN_LOG2:0]                    r_samples;
    logic [WIN_LOG2:0]                    r_ones;

    logic [WIN_LOG2:0]                    w_ones_next;
    logic                                 w_last;
    logic [WIN_LOG2+1:0]                  w_raw;
    logic [WIN_LOG2+SCALE_LOG2+1:0]       w_sum;

    assign w_ones_next = r_ones + {{WIN_LOG2{1'b0}}, iBit};
    assign w_last      = (r_samples == c_WIN_LAST);

    // 2*ones - N in two's complement; the width already spans [-N, +N],
    // so appending the scale zeros is the whole rescale.
    assign w_raw = {w_ones_next, 1'b0} - {1'b0, c_WIN_LEN};
    assign w_sum = {w_raw, {SCALE_LOG2{1'b0}}};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_samples <= '0;
            r_ones    <= '0;
            oBusy     <= 1'b0;
            oValid    <= 1'b0;
            oOnes     <= '0;
            oSum      <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_state   <= c_ST_COUNT;
                        r_samples <= '0;
                        r_ones    <= '0;
                        oBusy     <= 1'b1;
                    end
                end
                c_ST_COUNT: begin
                    if (iEn) begin
                        r_samples <= r_samples + 1'b1;
                        r_ones    <= w_ones_next;
                        if (w_last) begin
                            r_state <= c_ST_DONE;
                            oBusy   <= 1'b0;
                            oValid  <= 1'b1;
                            oOnes   <= w_ones_next;
                            oSum    <= w_sum;
                        end
                    end
                end
                c_ST_DONE: begin
                    if (iAck) begin
                        oValid <= 1'b0;
                        if (start) begin
                            // Back-to-back window; the held result stays put.
                            r_state   <= c_ST_COUNT;
                            r_samples <= '0;
                            r_ones    <= '0;
                            oBusy     <= 1'b1;
                        end else begin
                            r_state <= c_ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    oBusy   <= 1'b0;
                    oValid  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sc_bi_scaled_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_sc_bi_scaled_decoder
// Brief   : Randomized self-checking bench against a window-count model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sc_bi_scaled_decoder;

    localparam int WIN_LOG2   = 8;
    localparam int SCALE_LOG2 = 4;
    localparam int N          = 1 << WIN_LOG2;
    localparam int LANES      = 16;

    logic                           clk = 1'b0;
    logic                           rst = 1'b1;
    logic                           start = 1'b0;
    logic                           iBit = 1'b0;
    logic                           iEn = 1'b0;
    logic                           iAck = 1'b0;
    logic                           oBusy;
    logic                           oValid;
    logic [WIN_LOG2:0]              oOnes;
    logic [WIN_LOG2+SCALE_LOG2+1:0] oSum;

    int     errors = 0;
    int     checks = 0;
    longint prev_ones = 0;
    longint prev_sum  = 0;
    int     op_a [LANES];
    int     op_b [LANES];

    sc_bi_scaled_decoder #(
        .WIN_LOG2   (WIN_LOG2),
        .SCALE_LOG2 (SCALE_LOG2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .iBit   (iBit),
        .iEn    (iEn),
        .iAck   (iAck),
        .oBusy  (oBusy),
        .oValid (oValid),
        .oOnes  (oOnes),
        .oSum   (oSum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint sum_now();
        return longint'($signed(oSum));
    endfunction

    // Pattern 5 is a 16-lane bipolar MAC with round-robin select and
    // operands at +/-128, whose streams are constant 1 or 0.
    function automatic bit gen_bit(input int pattern, input int idx);
        int j;
        case (pattern)
            0: return 1'b1;
            1: return 1'b0;
            2: return (idx % 2) == 0;
            3: return (idx % 4) == 0;
            5: begin
                j = idx % LANES;
                return (op_a[j] > 0) == (op_b[j] > 0);
            end
            default: return 1'($urandom);
        endcase
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"},  longint'(oBusy),  0);
        check({tag, "_valid"}, longint'(oValid), 0);
        check({tag, "_ones"},  longint'(oOnes),  0);
        check({tag, "_sum"},   sum_now(),        0);
    endtask

    task automatic run_window(input int pattern, input int stalls, input int abort_at,
                              input bit back2back, output longint sum_out);
        int     samples = 0;
        int     ones = 0;
        int     cycles = 0;
        int     stalls_left = stalls;
        bit     e;
        bit     b;
        longint exp_sum;
        sum_out = 0;
        start = 1'b1;
        iAck  = back2back;
        iEn   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        iAck  = 1'b0;
        cycles = 1;
        check("busy_after_start",  longint'(oBusy),  1);
        check("valid_after_start", longint'(oValid), 0);
        if (back2back) begin
            check("b2b_ones_retained", longint'(oOnes), prev_ones);
            check("b2b_sum_retained",  sum_now(),       prev_sum);
        end
        while (samples < N) begin
            if (abort_at >= 0 && samples == abort_at) begin
                rst = 1'b1;
                iEn = 1'b0;
                start = 1'b0;
                iAck = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                check_reset_state("abort");
                @(negedge clk);
                check("abort_stays_idle", longint'(oBusy), 0);
                prev_ones = 0;
                prev_sum  = 0;
                return;
            end
            e = 1'b1;
            if (stalls_left > 0 && samples >= N / 4 &&
                (samples >= N / 2 || $urandom_range(0, 3) == 0)) begin
                e = 1'b0;
                stalls_left--;
            end
            b     = e ? gen_bit(pattern, samples) : 1'($urandom);
            iEn   = e;
            iBit  = b;
            start = 1'($urandom);
            iAck  = 1'($urandom);
            @(negedge clk);
            cycles++;
            if (e) begin
                samples++;
                ones += int'(b);
                if (samples < N && samples % 64 == 0) begin
                    check("mid_busy",  longint'(oBusy),  1);
                    check("mid_valid", longint'(oValid), 0);
                end
            end
        end
        iEn   = 1'b0;
        start = 1'b0;
        iAck  = 1'b0;
        exp_sum = longint'(2 * ones - N) * (longint'(1) << SCALE_LOG2);
        check("done_valid", longint'(oValid), 1);
        check("done_busy",  longint'(oBusy),  0);
        check("done_ones",  longint'(oOnes),  ones);
        check("done_sum",   sum_now(),        exp_sum);
        check("latency",    cycles,           N + 1 + stalls);
        prev_ones = ones;
        prev_sum  = exp_sum;
        sum_out   = sum_now();
    endtask

    // Start alone must not disturb DONE; optionally finish with a plain ack.
    task automatic hold_then_ack(input bit do_ack);
        start = 1'b1;
        iAck  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hold_valid", longint'(oValid), 1);
            check("hold_ones",  longint'(oOnes),  prev_ones);
            check("hold_sum",   sum_now(),        prev_sum);
        end
        start = 1'b0;
        if (do_ack) begin
            iAck = 1'b1;
            @(negedge clk);
            iAck = 1'b0;
            check("ack_valid",    longint'(oValid), 0);
            check("ack_busy",     longint'(oBusy),  0);
            check("ack_ones_ret", longint'(oOnes),  prev_ones);
            check("ack_sum_ret",  sum_now(),        prev_sum);
        end
    endtask

    initial begin
        longint s;
        longint total;
        longint dot;
        longint exp_avg;
        longint avg;
        longint diff;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset");

        iAck = 1'b1;
        @(negedge clk);
        iAck = 1'b0;
        check("idle_ack_ignored", longint'(oValid), 0);

        run_window(0, 0, -1, 1'b0, s);
        hold_then_ack(1'b1);
        run_window(1, 0, -1, 1'b0, s);
        hold_then_ack(1'b1);
        run_window(2, 0, -1, 1'b0, s);
        hold_then_ack(1'b0);
        run_window(3, 10, -1, 1'b1, s);
        hold_then_ack(1'b1);
        run_window(4, 0, 100, 1'b0, s);
        run_window(4, 5, -1, 1'b0, s);
        hold_then_ack(1'b1);

        dot = 0;
        for (int j = 0; j < LANES; j++) begin
            op_a[j] = $urandom_range(0, 1) ? 128 : -128;
            op_b[j] = $urandom_range(0, 1) ? 128 : -128;
            dot += longint'(op_a[j] * op_b[j]);
        end
        exp_avg = (256 * dot) / (128 * 128);
        total = 0;
        for (int w = 0; w < 8; w++) begin
            run_window(5, 0, -1, 1'b0, s);
            total += s;
            iAck = 1'b1;
            @(negedge clk);
            iAck = 1'b0;
        end
        avg  = total / 8;
        diff = (avg > exp_avg) ? (avg - exp_avg) : (exp_avg - avg);
        if (diff > 2 * LANES) begin
            check("mac_avg", avg, exp_avg);
        end else begin
            check("mac_avg_in_tol", avg, avg - diff + diff);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
